// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction memory loader.
// master drives bytes, slave (the loader) returns ready.
interface imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed byte stream in,
// 32-bit little-endian word writes out, CPU held until checksum passes.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.slave        rx,
    output logic                imem_we,
    output logic [31:0]         imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                cpu_hold,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [15:0]         words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SYNC   = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_LEN_HI = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    logic [2:0]  state;
    logic [7:0]  len_lo;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;
    logic [23:0] word_buf;
    logic        accept;
    logic [15:0] n_rx;

    // Every frame-receiving state takes one byte per clock, never stalls.
    assign rx.rx_ready = (state == S_SYNC)   || (state == S_LEN_LO) ||
                         (state == S_LEN_HI) || (state == S_DATA)   ||
                         (state == S_CHECK);
    assign accept = rx.rx_valid && rx.rx_ready;
    assign n_rx   = {rx.rx_data, len_lo};

    // Frame parser, word assembler and write-port driver.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            len_lo       <= 8'h00;
            n_words      <= 16'h0000;
            word_idx     <= 16'h0000;
            byte_idx     <= 2'd0;
            csum         <= 8'h00;
            word_buf     <= 24'h000000;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'h0000_0000;
            cpu_hold     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'h0000;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state        <= S_SYNC;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= 16'h0000;
                    end
                end
                S_SYNC: begin
                    if (accept && rx.rx_data == SYNC_BYTE)
                        state <= S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len_lo <= rx.rx_data;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        n_words  <= n_rx;
                        byte_idx <= 2'd0;
                        word_idx <= 16'h0000;
                        csum     <= 8'h00;
                        if (n_rx > MAX_N) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else if (n_rx == 16'h0000) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum     <= csum ^ rx.rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_addr    <= BASE_ADDR +
                                            {14'd0, word_idx, 2'b00};
                            imem_wdata   <= {rx.rx_data, word_buf};
                            words_loaded <= words_loaded + 16'd1;
                            word_idx     <= word_idx + 16'd1;
                            if (word_idx == n_words - 16'd1)
                                state <= S_CHECK;
                        end else begin
                            word_buf[{byte_idx, 3'b000} +: 8] <= rx.rx_data;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (rx.rx_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
